// File: rtl/inst_cache_2way.sv
// Two-way set-associative instruction cache: 8 sets, one word per line, LRU replacement.
// Hits answer one cycle after the strobe; misses fetch a single word from backing memory.
module inst_cache_2way (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        send_pulse,
    output logic [31:0] inst,
    output logic        ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t      state_reg, state_next;
    logic        ack_reg, ack_next;
    logic [31:0] inst_reg, inst_next;
    logic        mem_req_reg, mem_req_next;
    logic [31:0] mem_addr_reg, mem_addr_next;

    logic [7:0]  valid_reg [2];
    logic [7:0]  lru_reg;
    logic [26:0] tag_mem   [2][8];
    logic [31:0] data_mem  [2][8];

    logic [2:0]  req_idx, fill_idx, lru_idx;
    logic [26:0] req_tag, fill_tag;
    logic [1:0]  way_hit;
    logic        hit, hit_way, victim_way, lru_way;
    logic        fill_we, lru_we;

    assign req_idx  = addr[4:2];
    assign req_tag  = addr[31:5];
    assign fill_idx = mem_addr_reg[4:2];
    assign fill_tag = mem_addr_reg[31:5];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign way_hit[gi] = valid_reg[gi][req_idx] && (tag_mem[gi][req_idx] == req_tag);
        end
    endgenerate

    // Way0 takes priority on a double match.
    assign hit     = |way_hit;
    assign hit_way = ~way_hit[0];

    always_comb begin
        if (!valid_reg[0][fill_idx])
            victim_way = 1'b0;
        else if (!valid_reg[1][fill_idx])
            victim_way = 1'b1;
        else
            victim_way = lru_reg[fill_idx];
    end

    always_comb begin
        state_next    = state_reg;
        ack_next      = 1'b0;
        inst_next     = inst_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        fill_we       = 1'b0;
        lru_we        = 1'b0;
        lru_idx       = req_idx;
        lru_way       = hit_way;
        case (state_reg)
            IDLE: begin
                if (send_pulse) begin
                    if (hit) begin
                        ack_next  = 1'b1;
                        inst_next = data_mem[hit_way][req_idx];
                        lru_we    = 1'b1;
                    end else begin
                        state_next    = FILL;
                        mem_req_next  = 1'b1;
                        mem_addr_next = addr & 32'hFFFF_FFFC;
                    end
                end
            end
            FILL: begin
                if (mem_valid) begin
                    fill_we      = 1'b1;
                    lru_we       = 1'b1;
                    lru_idx      = fill_idx;
                    lru_way      = victim_way;
                    mem_req_next = 1'b0;
                    ack_next     = 1'b1;
                    inst_next    = mem_rdata;
                    state_next   = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ack_reg      <= 1'b0;
            inst_reg     <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            lru_reg      <= '0;
            valid_reg[0] <= '0;
            valid_reg[1] <= '0;
        end else begin
            state_reg    <= state_next;
            ack_reg      <= ack_next;
            inst_reg     <= inst_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            if (lru_we)
                lru_reg[lru_idx] <= ~lru_way;
            if (fill_we)
                valid_reg[victim_way][fill_idx] <= 1'b1;
        end
    end

    // Tag and data payload are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[victim_way][fill_idx]  <= fill_tag;
            data_mem[victim_way][fill_idx] <= mem_rdata;
        end
    end

    assign ack      = ack_reg;
    assign inst     = inst_reg;
    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_inst_cache_2way.sv
// Directed bench for inst_cache_2way: cold miss, hits, LRU replacement, ignored strobes,
// back-to-back hits and reset during a fill, against a 3-cycle echo memory model.
module tb_inst_cache_2way;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        send_pulse;
    logic [31:0] inst;
    logic        ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid = 1'b0;

    int total = 0;
    int bad   = 0;

    inst_cache_2way dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .send_pulse(send_pulse),
        .inst      (inst),
        .ack       (ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    // Memory answers 3 cycles after mem_req rises, echoing the address as data.
    logic mem_req_q = 1'b0;
    int   cnt = 0;
    assign mem_rdata = mem_addr;
    always @(posedge clk) begin
        mem_req_q <= mem_req;
        mem_valid <= 1'b0;
        if (mem_req && !mem_req_q)
            cnt <= 2;
        else if (cnt == 1) begin
            mem_valid <= 1'b1;
            cnt <= 0;
        end else if (cnt != 0)
            cnt <= cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One request; strobe is sampled at the posedge after the driving negedge.
    task automatic access(input logic [31:0] a, input bit exp_hit, input logic [31:0] exp_inst);
        int n;
        @(negedge clk);
        addr = a;
        send_pulse = 1'b1;
        @(negedge clk);
        send_pulse = 1'b0;
        if (exp_hit) begin
            check($sformatf("hit_ack_%08h", a), {31'd0, ack}, 32'd1);
            check($sformatf("hit_inst_%08h", a), inst, exp_inst);
            check($sformatf("hit_noreq_%08h", a), {31'd0, mem_req}, 32'd0);
        end else begin
            check($sformatf("miss_ack0_%08h", a), {31'd0, ack}, 32'd0);
            check($sformatf("miss_req_%08h", a), {31'd0, mem_req}, 32'd1);
            check($sformatf("miss_maddr_%08h", a), mem_addr, {a[31:2], 2'b00});
            n = 0;
            while (!ack && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("miss_lat_%08h", a), n, 32'd4);
            check($sformatf("miss_inst_%08h", a), inst, exp_inst);
            check($sformatf("miss_reqdrop_%08h", a), {31'd0, mem_req}, 32'd0);
        end
        @(negedge clk);
        check($sformatf("ack_single_%08h", a), {31'd0, ack}, 32'd0);
        check($sformatf("inst_hold_%08h", a), inst, exp_inst);
        $display("tx addr=0x%08h %s inst=0x%08h", a, exp_hit ? "hit " : "miss", inst);
    endtask

    initial begin
        int n;
        bit saw_ack;
        rst = 1'b1;
        addr = '0;
        send_pulse = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        rst = 1'b0;

        access(32'h0000_0010, 1'b0, 32'h0000_0010);   // cold miss
        access(32'h0000_0010, 1'b1, 32'h0000_0010);   // hit
        access(32'h0000_0013, 1'b1, 32'h0000_0010);   // unaligned hit

        // Set 1 conflict: 0x24 is LRU when 0x44 arrives
        access(32'h0000_0004, 1'b0, 32'h0000_0004);
        access(32'h0000_0024, 1'b0, 32'h0000_0024);
        access(32'h0000_0004, 1'b1, 32'h0000_0004);
        access(32'h0000_0044, 1'b0, 32'h0000_0044);
        access(32'h0000_0004, 1'b1, 32'h0000_0004);
        access(32'h0000_0024, 1'b0, 32'h0000_0024);

        // Strobe for 0x08 during the 0x0C fill must be dropped
        @(negedge clk);
        addr = 32'h0000_000C;
        send_pulse = 1'b1;
        @(negedge clk);
        addr = 32'h0000_0008;
        check("ign_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        send_pulse = 1'b0;
        n = 1;
        while (!ack && n < 20) begin
            check("ign_maddr_hold", mem_addr, 32'h0000_000C);
            @(negedge clk);
            n++;
        end
        check("ign_lat", n, 32'd4);
        check("ign_inst", inst, 32'h0000_000C);
        @(negedge clk);
        check("ign_single", {31'd0, ack}, 32'd0);
        $display("tx addr=0x0000000c miss with ignored strobe 0x00000008 inst=0x%08h", inst);
        access(32'h0000_0008, 1'b0, 32'h0000_0008);

        // Back-to-back hits: second strobe in the ack cycle of the first
        @(negedge clk);
        addr = 32'h0000_0010;
        send_pulse = 1'b1;
        @(negedge clk);
        check("b2b_ack1", {31'd0, ack}, 32'd1);
        check("b2b_inst1", inst, 32'h0000_0010);
        addr = 32'h0000_0004;
        @(negedge clk);
        send_pulse = 1'b0;
        check("b2b_ack2", {31'd0, ack}, 32'd1);
        check("b2b_inst2", inst, 32'h0000_0004);
        @(negedge clk);
        check("b2b_done", {31'd0, ack}, 32'd0);
        $display("tx back-to-back hits 0x00000010, 0x00000004 inst=0x%08h", inst);

        // Reset one cycle after mem_req rises aborts the fill
        @(negedge clk);
        addr = 32'h0000_0030;
        send_pulse = 1'b1;
        @(negedge clk);
        send_pulse = 1'b0;
        check("rfill_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rfill_req0", {31'd0, mem_req}, 32'd0);
        check("rfill_ack0", {31'd0, ack}, 32'd0);
        check("rfill_maddr0", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        check("rfill_no_ack", {31'd0, saw_ack}, 32'd0);
        $display("tx reset during fill of 0x00000030, no ack");
        access(32'h0000_0010, 1'b0, 32'h0000_0010);   // previously a hit

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
